mem_arbiter: RTL
================

# mem_arbiter

Two-client arbiter that shares one `MemIntf` memory port between the fetch unit (client 0) and the data/load-store path (client 1). Requests pass combinationally from the granted client to memory. Responses return in request order and are routed back to the originating client through an internal routing FIFO of client IDs. The block sits between `Fetch`/LSU and the single-ported memory or cache.

## Interface
Parameters:
- `p_addr_bits`, 32: address width of `MemIntf` messages.
- `p_data_bits`, 32: data width of `MemIntf` messages.
- `p_opaq_bits`, 8: opaque width. Passed through untouched, never interpreted.
- `p_route_depth`, 4: maximum outstanding requests (routing FIFO entries). Must be a power of 2, ≥ 2.

Ports:
- `clk`  input  1  clock, all state on posedge.
- `rst`  input  1  synchronous, active-high reset.
- `cli0`  MemIntf.server  modport  client 0 (fetch). Request: `op`, `opaque`, `addr`, `len`, `data`. Response: same fields.
- `cli1`  MemIntf.server  modport  client 1 (data path), same fields.
- `mem`  MemIntf.client  modport  shared downstream memory port.

## Operation
- State:
  - routing FIFO of 1-bit client IDs, `p_route_depth` entries, with read/write pointers and a `$clog2(p_route_depth)+1`-bit count;
  - 1-bit round-robin pointer `prio`, which selects the preferred client.
- Grant (combinational, from `req_val` only, never from `req_rdy`):
  - Only one client valid: that client is granted.
  - Both valid: client `prio` is granted.
- Request path:
  - `mem.req_val = (cli0.req_val | cli1.req_val) & !full`.
  - `mem.req_msg` = granted client's message, bit-exact.
  - `cliN.req_rdy = granted==N & mem.req_rdy & !full`. The non-granted client sees `req_rdy=0`.
- On `mem` request transfer:
  - push granted ID into the FIFO;
  - `prio <= ~granted_id`.
  - `prio` is unchanged when no transfer occurs.
- Response path:
  - FIFO non-empty: head ID `h` selects the destination. `cli{h}.resp_val = mem.resp_val`, `cli{h}.resp_msg = mem.resp_msg`, `mem.resp_rdy = cli{h}.resp_rdy`. The other client sees `resp_val=0`.
  - FIFO empty: `mem.resp_rdy=0` and both `resp_val=0`. A response arriving with no outstanding request is a protocol violation and stalls.
  - On `mem` response transfer: pop the FIFO.
- Boundary conditions:
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Full: no new grant, even if a pop happens in the same cycle. There is no full-bypass; new requests wait one cycle.
  - Empty: no same-cycle bypass. A response to a request accepted in cycle t is routable from cycle t+1.
  - Pointer wrap: natural modulo `p_route_depth`.
- Reset (applies mid-operation too): FIFO emptied, `prio=0`. Memory must be reset together with this block; stale responses are not routed.

## Timing
- Request and response paths have zero-cycle combinational latency.
- FIFO occupancy and `prio` update at the posedge after a transfer.
- Output values during/after reset:
  - `mem.req_val` = OR of client `req_val`s (FIFO empty);
  - `mem.resp_rdy=0`;
  - `cli0.resp_val=0`, `cli1.resp_val=0`;
  - `cliN.req_rdy` follow the grant rules with `prio=0`.
- Sustained throughput: one request per cycle with `p_route_depth` outstanding. Total throughput is one request per cycle shared between clients; when both clients stream, each gets every other cycle.
- No combinational path from `mem.resp_*` to `mem.req_*`. The `req_rdy` paths are combinational from `mem.req_rdy`.

## Configuration
- `MEM_ARBITER_FIXED_PRIO_EN`
  - Defined: client 1 always wins when both are valid; `prio` is not implemented (tied to 1).
  - Undefined (default): round-robin as above.
- FIFO routing and all other behaviour are identical in both builds.

## Test plan
- Single client: `cli0` issues reads to 0x0, 0x4, 0x8 back-to-back, memory `req_rdy=1`, responses return 1 cycle later. Required: 3 `mem` transfers on consecutive cycles; `cli0` receives data in order with original opaques; `cli1.resp_val` never asserted.
- Contention: both clients valid every cycle for 6 cycles after reset, responses returned promptly so the FIFO never fills. Required: grant sequence 0,1,0,1,0,1. With `MEM_ARBITER_FIXED_PRIO_EN`: 1,1,1,1,1,1 and `cli0.req_rdy=0` throughout.
- Routing: interleaved grants 0,1,1,0; memory delays all responses 5 cycles. Required: responses delivered to `cli0`, `cli1`, `cli1`, `cli0` in that order, message fields unmodified.
- Full: `p_route_depth=4`, memory withholds responses. Required: 4 requests accepted, then `mem.req_val=0` and both `req_rdy=0`. After one response is accepted, a new request is accepted on the following cycle, not the same cycle.
- Backpressure: `cli1` holds `resp_rdy=0` for 3 cycles with its response at the FIFO head. Required: `mem.resp_rdy=0` for 3 cycles; FIFO count and `cli0` delivery unchanged until `cli1` accepts.
- Reset mid-flight: assert `rst` with 3 requests outstanding. Required: next cycle FIFO empty, `mem.resp_rdy=0`, `prio=0`, and the next contended grant goes to `cli0`.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-client memory arbiter with in-order response routing (option: MEM_ARBITER_FIXED_PRIO_EN)
module mem_arbiter #(
   parameter int p_addr_bits   = 32,
   parameter int p_data_bits   = 32,
   parameter int p_opaq_bits   = 8,
   parameter int p_route_depth = 4
) (
   input  logic                               clk,
   input  logic                               rst,

   input  logic                               cli0_req_val,
   output logic                               cli0_req_rdy,
   input  logic [2:0]                         cli0_req_op,
   input  logic [p_opaq_bits-1:0]             cli0_req_opaque,
   input  logic [p_addr_bits-1:0]             cli0_req_addr,
   input  logic [$clog2(p_data_bits/8)-1:0]   cli0_req_len,
   input  logic [p_data_bits-1:0]             cli0_req_data,
   output logic                               cli0_resp_val,
   input  logic                               cli0_resp_rdy,
   output logic [2:0]                         cli0_resp_op,
   output logic [p_opaq_bits-1:0]             cli0_resp_opaque,
   output logic [p_addr_bits-1:0]             cli0_resp_addr,
   output logic [$clog2(p_data_bits/8)-1:0]   cli0_resp_len,
   output logic [p_data_bits-1:0]             cli0_resp_data,

   input  logic                               cli1_req_val,
   output logic                               cli1_req_rdy,
   input  logic [2:0]                         cli1_req_op,
   input  logic [p_opaq_bits-1:0]             cli1_req_opaque,
   input  logic [p_addr_bits-1:0]             cli1_req_addr,
   input  logic [$clog2(p_data_bits/8)-1:0]   cli1_req_len,
   input  logic [p_data_bits-1:0]             cli1_req_data,
   output logic                               cli1_resp_val,
   input  logic                               cli1_resp_rdy,
   output logic [2:0]                         cli1_resp_op,
   output logic [p_opaq_bits-1:0]             cli1_resp_opaque,
   output logic [p_addr_bits-1:0]             cli1_resp_addr,
   output logic [$clog2(p_data_bits/8)-1:0]   cli1_resp_len,
   output logic [p_data_bits-1:0]             cli1_resp_data,

   output logic                               mem_req_val,
   input  logic                               mem_req_rdy,
   output logic [2:0]                         mem_req_op,
   output logic [p_opaq_bits-1:0]             mem_req_opaque,
   output logic [p_addr_bits-1:0]             mem_req_addr,
   output logic [$clog2(p_data_bits/8)-1:0]   mem_req_len,
   output logic [p_data_bits-1:0]             mem_req_data,
   input  logic                               mem_resp_val,
   output logic                               mem_resp_rdy,
   input  logic [2:0]                         mem_resp_op,
   input  logic [p_opaq_bits-1:0]             mem_resp_opaque,
   input  logic [p_addr_bits-1:0]             mem_resp_addr,
   input  logic [$clog2(p_data_bits/8)-1:0]   mem_resp_len,
   input  logic [p_data_bits-1:0]             mem_resp_data
);

   localparam int PTR_BITS = $clog2(p_route_depth);
   localparam int CNT_BITS = PTR_BITS + 1;

   logic                route_id [p_route_depth];
   logic [PTR_BITS-1:0] wr_ptr;
   logic [PTR_BITS-1:0] rd_ptr;
   logic [CNT_BITS-1:0] count;
   logic                prio;
   logic                grant;
   logic                full;
   logic                empty;
   logic                head;
   logic                push;
   logic                pop;

   assign full  = (count == CNT_BITS'(p_route_depth));
   assign empty = (count == '0);
   assign head  = route_id[rd_ptr];

   // Grant depends only on the valids so req_rdy never feeds back into itself.
   assign grant = cli1_req_val & (~cli0_req_val | prio);

   assign mem_req_val    = (cli0_req_val | cli1_req_val) & ~full;
   assign cli0_req_rdy   = ~grant & mem_req_rdy & ~full;
   assign cli1_req_rdy   =  grant & mem_req_rdy & ~full;
   assign mem_req_op     = grant ? cli1_req_op     : cli0_req_op;
   assign mem_req_opaque = grant ? cli1_req_opaque : cli0_req_opaque;
   assign mem_req_addr   = grant ? cli1_req_addr   : cli0_req_addr;
   assign mem_req_len    = grant ? cli1_req_len    : cli0_req_len;
   assign mem_req_data   = grant ? cli1_req_data   : cli0_req_data;

   assign push = mem_req_val & mem_req_rdy;
   assign pop  = mem_resp_val & mem_resp_rdy;

   // An empty FIFO means no owner for a response, so it is held off rather than dropped.
   assign mem_resp_rdy  = ~empty & (head ? cli1_resp_rdy : cli0_resp_rdy);
   assign cli0_resp_val = mem_resp_val & ~empty & ~head;
   assign cli1_resp_val = mem_resp_val & ~empty &  head;

   assign cli0_resp_op     = mem_resp_op;
   assign cli0_resp_opaque = mem_resp_opaque;
   assign cli0_resp_addr   = mem_resp_addr;
   assign cli0_resp_len    = mem_resp_len;
   assign cli0_resp_data   = mem_resp_data;
   assign cli1_resp_op     = mem_resp_op;
   assign cli1_resp_opaque = mem_resp_opaque;
   assign cli1_resp_addr   = mem_resp_addr;
   assign cli1_resp_len    = mem_resp_len;
   assign cli1_resp_data   = mem_resp_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_BITS'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
         count <= count + CNT_BITS'(push) - CNT_BITS'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) route_id[wr_ptr] <= grant;
   end

`ifdef MEM_ARBITER_FIXED_PRIO_EN
   assign prio = 1'b1;
`else
   always_ff @(posedge clk) begin
      if (rst)       prio <= 1'b0;
      else if (push) prio <= ~grant;
   end
`endif

endmodule
